// File: rtl/req_grant_arbiter_if.sv
// Request/grant bundle between requesters and the shared-resource arbiter.
// master = requester side, slave = arbiter side.
interface req_grant_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/req_grant_arbiter.sv
// 4-way request/grant arbiter, hold-until-release with hold timeout and ban.
// Fixed priority (req[3] highest) by default; ROUND_ROBIN_EN selects rotating priority.
module req_grant_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    req_grant_arbiter_if.slave   bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit TMO_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] LIMIT =
        HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        gnt_id_q, gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q, timeout_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]        ban_q, ban_d;
    logic [1:0]        rr_last_q, rr_last_d;

    logic [3:0]        eligible;
    logic [1:0]        win;
    logic              found;

    assign eligible = bus.req & ~ban_q;

`ifdef ROUND_ROBIN_EN
    logic [1:0] idx;

    // Search rr_last-1, -2, -3, then rr_last itself.
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_last_q - 2'(k);
            if (!found && eligible[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (eligible[i]) begin
                win   = 2'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        ban_d       = ban_q & bus.req;
        rr_last_d   = rr_last_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = BUSY;
                    grant_d     = 4'b0001 << win;
                    gnt_id_d    = win;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    rr_last_d   = win;
                end
            end
            BUSY: begin
                // Owner dropping on the limit edge wins over the timeout.
                if (!bus.req[gnt_id_q]) begin
                    state_d     = IDLE;
                    grant_d     = 4'b0000;
                    gnt_id_d    = 2'd0;
                    gnt_valid_d = 1'b0;
                end else if (TMO_EN && hold_cnt_q == LIMIT) begin
                    state_d         = IDLE;
                    grant_d         = 4'b0000;
                    gnt_id_d        = 2'd0;
                    gnt_valid_d     = 1'b0;
                    timeout_d       = 1'b1;
                    ban_d[gnt_id_q] = 1'b1;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            ban_q       <= 4'b0000;
            rr_last_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            ban_q       <= ban_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Directed bench for req_grant_arbiter with MAX_HOLD=4.
// Checks reset, priority, dead cycle, timeout/ban, async reset and RR/fixed order.
module tb_req_grant_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    req_grant_arbiter_if bif ();

    req_grant_arbiter #(
        .MAX_HOLD (4),
        .HOLD_W   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ev(input logic [3:0] g,
                                      input logic [1:0] id,
                                      input logic to);
        return {to, |g, id, g};
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] id);
        logic [3:0] one;
        one = 4'b0001;
        return one << id;
    endfunction

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {bif.timeout, bif.gnt_valid, bif.gnt_id, bif.grant};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] seq [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef ROUND_ROBIN_EN
        seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
        seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        rst_n   = 1'b1;
        bif.req = 4'b1111;
        #1 rst_n = 1'b0;
        #2 chk("t1_rst", ev(4'b0000, 2'd0, 1'b0));
        @(negedge clk);
        chk("t1_rst_hold", ev(4'b0000, 2'd0, 1'b0));
        rst_n = 1'b1;
        cyc();
        chk("t1_grant3", ev(4'b1000, 2'd3, 1'b0));
        bif.req = 4'b0000;
        cyc();
        chk("t1_release", ev(4'b0000, 2'd0, 1'b0));

        // Test 2: fixed priority, 3-cycle hold, one dead cycle
        bif.req = 4'b0110;
        cyc();
        chk("t2_g2_c1", ev(4'b0100, 2'd2, 1'b0));
        cyc();
        chk("t2_g2_c2", ev(4'b0100, 2'd2, 1'b0));
        cyc();
        chk("t2_g2_c3", ev(4'b0100, 2'd2, 1'b0));
        bif.req = 4'b0010;
        cyc();
        chk("t2_dead", ev(4'b0000, 2'd0, 1'b0));
        cyc();
        chk("t2_g1", ev(4'b0010, 2'd1, 1'b0));
        bif.req = 4'b0000;
        cyc();
        chk("t2_rel", ev(4'b0000, 2'd0, 1'b0));

        // Test 3: forced release after 4 cycles, ban until toggle
        bif.req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("t3_hold_c%0d", i + 1), ev(4'b0010, 2'd1, 1'b0));
        end
        cyc();
        chk("t3_timeout", ev(4'b0000, 2'd0, 1'b1));
        cyc();
        chk("t3_tmo_pulse_end", ev(4'b0000, 2'd0, 1'b0));
        cyc();
        chk("t3_banned", ev(4'b0000, 2'd0, 1'b0));
        bif.req = 4'b0000;
        cyc();
        chk("t3_low", ev(4'b0000, 2'd0, 1'b0));
        bif.req = 4'b0010;
        cyc();
        chk("t3_regrant", ev(4'b0010, 2'd1, 1'b0));

        // Test 4: drop on the 4th cycle counts as normal release
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk($sformatf("t4_hold_c%0d", i + 1), ev(4'b0010, 2'd1, 1'b0));
        end
        bif.req = 4'b0000;
        cyc();
        chk("t4_no_tmo", ev(4'b0000, 2'd0, 1'b0));
        bif.req = 4'b0010;
        cyc();
        chk("t4_no_ban", ev(4'b0010, 2'd1, 1'b0));
        bif.req = 4'b0000;
        cyc();
        chk("t4_rel", ev(4'b0000, 2'd0, 1'b0));

        // Test 6: async reset mid-grant clears outputs and ban
        bif.req = 4'b0010;
        for (int i = 0; i < 4; i++) cyc();
        chk("t6_pre_c4", ev(4'b0010, 2'd1, 1'b0));
        cyc();
        chk("t6_timeout", ev(4'b0000, 2'd0, 1'b1));
        bif.req = 4'b1010;
        cyc();
        chk("t6_g3", ev(4'b1000, 2'd3, 1'b0));
        #2 rst_n = 1'b0;
        #1 chk("t6_async_rst", ev(4'b0000, 2'd0, 1'b0));
        bif.req = 4'b0010;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("t6_ban_clr", ev(4'b0010, 2'd1, 1'b0));
        bif.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Test 5: all request, owner drops and re-raises
        bif.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("t5_g%0d", i), ev(oh(seq[i]), seq[i], 1'b0));
            bif.req = 4'b1111 & ~oh(seq[i]);
            cyc();
            chk($sformatf("t5_dead%0d", i), ev(4'b0000, 2'd0, 1'b0));
            bif.req = 4'b1111;
        end
        bif.req = 4'b0000;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
